evm_controller: RTL and testbench
=================================

// Module: evm_controller
// PURPOSE
//  Voting-machine core that evm_interface drives and monitors: responds to the evm_driver_cb outputs and
//  produces every signal evm_monitor_cb samples. Sequences power-on, per-voter ballot and session close.
//  Keeps saturating per-candidate tallies and serves result/winner queries after close.
// PARAMETERS
//  WIDTH  7  width of each candidate tally and of results
// PORTS
//  clk                  in   1      single clock, all state on posedge
//  rst                  in   1      reset, asynchronous, active-low
//  switch_on_evm        in   1      machine power/enable
//  candidate_ready      in   1      voter admitted, ballot open
//  vote_candidate_1     in   1      vote button, candidate 1
//  vote_candidate_2     in   1      vote button, candidate 2
//  vote_candidate_3     in   1      vote button, candidate 3
//  voting_session_done  in   1      close session
//  display_results      in   2      01/10/11 = show candidate 1/2/3 tally; 00 = none
//  display_winner       in   1      show winner; priority over display_results
//  candidate_name       out  3      one-hot candidate shown (001/010/100); 000 = none
//  invalid_results      out  1      query has no unique answer (tie / all zero)
//  results              out  WIDTH  displayed count
//  voting_in_progress   out  1      ballot open (state VOTE)
//  voting_done          out  1      session closed (state DONE)
// BEHAVIOUR
//  - rst=0 (async): state OFF, all tallies 0, all outputs 0. Every output is registered.
//  - OFF:  switch_on_evm=1 -> IDLE.
//  - IDLE: voting_session_done=1 -> DONE (wins over candidate_ready); else candidate_ready=1 -> VOTE.
//  - VOTE: voting_in_progress=1.
//    - Exactly one vote line high: that tally +1, saturating at 2**WIDTH-1 -> HOLD.
//    - Two or more lines high: no count, stay in VOTE.
//    - candidate_ready=0 with no vote: ballot abandoned -> IDLE.
//  - HOLD: candidate_ready=0 and all vote lines 0 -> IDLE. A held button counts once.
//  - switch_on_evm=0 in IDLE/VOTE/HOLD -> OFF; tallies kept, outputs cleared; a pending VOTE counts nothing.
//  - DONE: voting_done=1, voting_in_progress=0. Vote/ready/switch ignored. Exit only via rst.
//  - DONE queries: outputs valid 1 cycle after the inputs are sampled.
//    - display_winner=1: unique max -> its candidate_name and count, invalid_results=0.
//    - display_winner=1: tie at max (incl. all zero) -> candidate_name=000, results=max, invalid_results=1.
//    - display_results 01/10/11: that candidate's tally, invalid_results=0.
//    - display_results 00: results=0, candidate_name=000.
//  - Outside DONE: candidate_name, results, invalid_results held at 0.
//  - Tally visibility: increment seen in results one query cycle after the count cycle.
// CONFIGURATION
//  EVM_TOTAL_DISPLAY_EN defined: display_results=00 in DONE shows the sum of all tallies
//    (saturating at 2**WIDTH-1), candidate_name=111.
//  Undefined: 00 shows results=0, candidate_name=000.
// STRUCTURE
//  evm_pkg: state enum {OFF,IDLE,VOTE,HOLD,DONE}; one-hot candidate codes CAND_1/2/3 and CAND_NONE;
//    display_results select encodings.
//  Sub-module evm_winner_cmp: combinational 3-way max, winner one-hot and tie flag over the tallies.
//  Top holds FSM, tallies and output registers.
// TESTING
//  1. Reset, switch_on, 3 ballots for candidate 2, session_done, display_results=10
//     -> results=3, candidate_name=010, voting_done=1.
//  2. Ballot with vote_candidate_1 and vote_candidate_3 together, then vote_candidate_1 alone
//     -> tally1=1, tally3=0.
//  3. vote_candidate_1 held 10 cycles under candidate_ready -> tally1=1; voting_in_progress low after first count.
//  4. WIDTH=7, 130 ballots for candidate 3, query 11 -> results=127 (saturated).
//  5. Tallies 2/2/1, display_winner=1 -> invalid_results=1, candidate_name=000, results=2.
//  6. rst=0 asserted mid-VOTE -> all outputs 0 same cycle; after release a query shows tallies 0.

Source files
------------

// File: rtl/evm_pkg.sv
// ---------------------------------------------------------------------------
// evm_pkg
// Shared types and constants for the voting-machine controller.
//   evm_state_t   : controller states OFF, IDLE, VOTE, HOLD, DONE
//   CAND_*        : one-hot candidate codes driven on candidate_name
//   SEL_*         : encodings of the display_results query select
// ---------------------------------------------------------------------------
package evm_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        IDLE = 3'd1,
        VOTE = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } evm_state_t;

    localparam logic [2:0] CAND_NONE = 3'b000;
    localparam logic [2:0] CAND_1    = 3'b001;
    localparam logic [2:0] CAND_2    = 3'b010;
    localparam logic [2:0] CAND_3    = 3'b100;
    localparam logic [2:0] CAND_ALL  = 3'b111;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_C1    = 2'b01;
    localparam logic [1:0] SEL_C2    = 2'b10;
    localparam logic [1:0] SEL_C3    = 2'b11;

endpackage

// File: rtl/evm_winner_cmp.sv
// ---------------------------------------------------------------------------
// evm_winner_cmp
// Combinational three-way maximum over the candidate tallies.
// Ports:
//   tally_1/2/3 : in  WIDTH  current tallies
//   max_count   : out WIDTH  largest tally
//   winner      : out 3      one-hot code of the unique maximum, CAND_NONE on tie
//   tie         : out 1      more than one tally equals the maximum (incl. all zero)
// ---------------------------------------------------------------------------
import evm_pkg::*;

module evm_winner_cmp #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] tally_1,
    input  logic [WIDTH-1:0] tally_2,
    input  logic [WIDTH-1:0] tally_3,
    output logic [WIDTH-1:0] max_count,
    output logic [2:0]       winner,
    output logic             tie
);

    logic [WIDTH-1:0] max_12;
    logic             eq_1;
    logic             eq_2;
    logic             eq_3;

    always_comb begin
        max_12    = (tally_1 >= tally_2) ? tally_1 : tally_2;
        max_count = (max_12 >= tally_3) ? max_12 : tally_3;
        eq_1      = (tally_1 == max_count);
        eq_2      = (tally_2 == max_count);
        eq_3      = (tally_3 == max_count);
        // Any two tallies sharing the maximum means there is no unique winner.
        tie       = (eq_1 & eq_2) | (eq_1 & eq_3) | (eq_2 & eq_3);
        winner    = tie ? CAND_NONE : {eq_3, eq_2, eq_1};
    end

endmodule

// File: rtl/evm_controller.sv
// ---------------------------------------------------------------------------
// evm_controller
// Voting-machine core: sequences power-on, one ballot per admitted voter and
// session close, keeps saturating per-candidate tallies and answers
// result/winner queries once the session is closed. All outputs registered.
// Ports:
//   clk, rst (async, active-low)
//   switch_on_evm, candidate_ready, vote_candidate_1/2/3, voting_session_done
//   display_results[1:0], display_winner             : query inputs (DONE only)
//   candidate_name[2:0], invalid_results, results     : query answer
//   voting_in_progress (state VOTE), voting_done (state DONE)
// Build option:
//   EVM_TOTAL_DISPLAY_EN : display_results=00 in DONE shows the saturated sum
//                          of all tallies with candidate_name=111; otherwise
//                          00 shows results=0, candidate_name=000.
// ---------------------------------------------------------------------------
import evm_pkg::*;

module evm_controller #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             switch_on_evm,
    input  logic             candidate_ready,
    input  logic             vote_candidate_1,
    input  logic             vote_candidate_2,
    input  logic             vote_candidate_3,
    input  logic             voting_session_done,
    input  logic [1:0]       display_results,
    input  logic             display_winner,
    output logic [2:0]       candidate_name,
    output logic             invalid_results,
    output logic [WIDTH-1:0] results,
    output logic             voting_in_progress,
    output logic             voting_done
);

    localparam logic [WIDTH-1:0] TALLY_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TALLY_MAX = {WIDTH{1'b1}};

    evm_state_t       state;
    logic [WIDTH-1:0] tally_1;
    logic [WIDTH-1:0] tally_2;
    logic [WIDTH-1:0] tally_3;

    logic [WIDTH-1:0] max_count;
    logic [2:0]       winner;
    logic             tie;

    logic             one_vote;
    logic             no_vote;

    logic [2:0]       q_name;
    logic [WIDTH-1:0] q_results;
    logic             q_invalid;

    evm_winner_cmp #(.WIDTH(WIDTH)) u_winner_cmp (
        .tally_1   (tally_1),
        .tally_2   (tally_2),
        .tally_3   (tally_3),
        .max_count (max_count),
        .winner    (winner),
        .tie       (tie)
    );

    // Exactly one vote line high is a valid ballot; none high allows abandon.
    assign one_vote = (vote_candidate_1 ^ vote_candidate_2 ^ vote_candidate_3)
                    & ~(vote_candidate_1 & vote_candidate_2 & vote_candidate_3);
    assign no_vote  = ~(vote_candidate_1 | vote_candidate_2 | vote_candidate_3);

`ifdef EVM_TOTAL_DISPLAY_EN
    logic [WIDTH+1:0] total_raw;
    logic [WIDTH-1:0] total_sat;

    // Two guard bits hold the full sum of three tallies before saturation.
    assign total_raw = {2'b00, tally_1} + {2'b00, tally_2} + {2'b00, tally_3};
    assign total_sat = (total_raw[WIDTH+1:WIDTH] != 2'b00) ? TALLY_MAX
                                                           : total_raw[WIDTH-1:0];
`endif

    // Answer for the query currently on the inputs; registered only in DONE.
    always_comb begin
        q_name    = CAND_NONE;
        q_results = '0;
        q_invalid = 1'b0;
        if (display_winner) begin
            q_name    = winner;
            q_results = max_count;
            q_invalid = tie;
        end else begin
            case (display_results)
                SEL_C1: begin
                    q_name    = CAND_1;
                    q_results = tally_1;
                end
                SEL_C2: begin
                    q_name    = CAND_2;
                    q_results = tally_2;
                end
                SEL_C3: begin
                    q_name    = CAND_3;
                    q_results = tally_3;
                end
                default: begin
`ifdef EVM_TOTAL_DISPLAY_EN
                    q_name    = CAND_ALL;
                    q_results = total_sat;
`else
                    q_name    = CAND_NONE;
                    q_results = '0;
`endif
                end
            endcase
        end
    end

    // FSM, tallies and output registers. Outputs default to 0 each cycle and
    // are set from the state being entered, so they track the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= OFF;
            tally_1            <= '0;
            tally_2            <= '0;
            tally_3            <= '0;
            candidate_name     <= CAND_NONE;
            invalid_results    <= 1'b0;
            results            <= '0;
            voting_in_progress <= 1'b0;
            voting_done        <= 1'b0;
        end else begin
            candidate_name     <= CAND_NONE;
            invalid_results    <= 1'b0;
            results            <= '0;
            voting_in_progress <= 1'b0;
            voting_done        <= 1'b0;
            case (state)
                OFF: begin
                    if (switch_on_evm) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!switch_on_evm) begin
                        state <= OFF;
                    end else if (voting_session_done) begin
                        state       <= DONE;
                        voting_done <= 1'b1;
                    end else if (candidate_ready) begin
                        state              <= VOTE;
                        voting_in_progress <= 1'b1;
                    end
                end
                VOTE: begin
                    if (!switch_on_evm) begin
                        state <= OFF;
                    end else if (one_vote) begin
                        if (vote_candidate_1 && tally_1 != TALLY_MAX) begin
                            tally_1 <= tally_1 + TALLY_ONE;
                        end
                        if (vote_candidate_2 && tally_2 != TALLY_MAX) begin
                            tally_2 <= tally_2 + TALLY_ONE;
                        end
                        if (vote_candidate_3 && tally_3 != TALLY_MAX) begin
                            tally_3 <= tally_3 + TALLY_ONE;
                        end
                        state <= HOLD;
                    end else if (!candidate_ready && no_vote) begin
                        state <= IDLE;
                    end else begin
                        voting_in_progress <= 1'b1;
                    end
                end
                HOLD: begin
                    // Wait for full release so a held button counts only once.
                    if (!switch_on_evm) begin
                        state <= OFF;
                    end else if (!candidate_ready && no_vote) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    voting_done     <= 1'b1;
                    candidate_name  <= q_name;
                    results         <= q_results;
                    invalid_results <= q_invalid;
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evm_controller.sv
// ---------------------------------------------------------------------------
// tb_evm_controller
// Self-checking bench for evm_controller (WIDTH=7). Query expectations come
// from a bench-side tally model and are queued when the query is driven, then
// popped and compared against the registered answer one cycle later.
// ---------------------------------------------------------------------------
module tb_evm_controller;

    localparam int WIDTH = 7;
    localparam int TMAX  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             switch_on_evm;
    logic             candidate_ready;
    logic             vote_candidate_1;
    logic             vote_candidate_2;
    logic             vote_candidate_3;
    logic             voting_session_done;
    logic [1:0]       display_results;
    logic             display_winner;
    logic [2:0]       candidate_name;
    logic             invalid_results;
    logic [WIDTH-1:0] results;
    logic             voting_in_progress;
    logic             voting_done;

    typedef struct {
        string      tag;
        logic [2:0] name;
        int         res;
        logic       inv;
    } expect_t;

    expect_t scoreboard[$];
    int      tal[3];
    int      compared   = 0;
    int      mismatched = 0;

    evm_controller #(.WIDTH(WIDTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .switch_on_evm       (switch_on_evm),
        .candidate_ready     (candidate_ready),
        .vote_candidate_1    (vote_candidate_1),
        .vote_candidate_2    (vote_candidate_2),
        .vote_candidate_3    (vote_candidate_3),
        .voting_session_done (voting_session_done),
        .display_results     (display_results),
        .display_winner      (display_winner),
        .candidate_name      (candidate_name),
        .invalid_results     (invalid_results),
        .results             (results),
        .voting_in_progress  (voting_in_progress),
        .voting_done         (voting_done)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports each check.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic rdy, input logic v1,
                                 input logic v2, input logic v3, input logic done,
                                 input logic [1:0] sel, input logic win);
        switch_on_evm       = sw;
        candidate_ready     = rdy;
        vote_candidate_1    = v1;
        vote_candidate_2    = v2;
        vote_candidate_3    = v3;
        voting_session_done = done;
        display_results     = sel;
        display_winner      = win;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected answer from the bench tally model.
    task automatic predict(input logic [1:0] sel, input logic win, input string tag);
        expect_t e;
        int      mx;
        int      hits;
        int      idx;
        e.tag  = tag;
        e.name = 3'b000;
        e.res  = 0;
        e.inv  = 1'b0;
        if (win) begin
            mx = 0;
            for (int i = 0; i < 3; i++) if (tal[i] > mx) mx = tal[i];
            hits = 0;
            idx  = 0;
            for (int i = 0; i < 3; i++) begin
                if (tal[i] == mx) begin
                    hits++;
                    idx = i;
                end
            end
            e.res = mx;
            if (hits == 1) e.name = 3'(1 << idx);
            else           e.inv  = 1'b1;
        end else if (sel != 2'b00) begin
            e.res  = tal[sel - 1];
            e.name = 3'(1 << (sel - 1));
        end else begin
`ifdef EVM_TOTAL_DISPLAY_EN
            e.res  = tal[0] + tal[1] + tal[2];
            if (e.res > TMAX) e.res = TMAX;
            e.name = 3'b111;
`endif
        end
        scoreboard.push_back(e);
    endtask

    task automatic compareScoreboard();
        expect_t e;
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({e.tag, "_name"},    int'(candidate_name),  int'(e.name));
            checkOutput({e.tag, "_results"}, int'(results),         e.res);
            checkOutput({e.tag, "_invalid"}, int'(invalid_results), int'(e.inv));
        end
    endtask

    task automatic doReset(input string tag);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        checkOutput({tag, "_rst_name"}, int'(candidate_name), 0);
        checkOutput({tag, "_rst_results"}, int'(results), 0);
        checkOutput({tag, "_rst_invalid"}, int'(invalid_results), 0);
        checkOutput({tag, "_rst_vip"}, int'(voting_in_progress), 0);
        checkOutput({tag, "_rst_done"}, int'(voting_done), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tal[i] = 0;
        scoreboard.delete();
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
    endtask

    // Admit voter, press the given buttons for one cycle, then release.
    task automatic castBallot(input logic v1, input logic v2, input logic v3, input bit check);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 0);
        tick();
        if (check) checkOutput("ballot_vip", int'(voting_in_progress), 1);
        applyStimulus(1, 1, v1, v2, v3, 0, 2'b00, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        if ((int'(v1) + int'(v2) + int'(v3)) == 1) begin
            if (v1 && tal[0] < TMAX) tal[0]++;
            if (v2 && tal[1] < TMAX) tal[1]++;
            if (v3 && tal[2] < TMAX) tal[2]++;
        end
    endtask

    task automatic closeSession();
        applyStimulus(1, 0, 0, 0, 0, 1, 2'b00, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
        checkOutput("close_done", int'(voting_done), 1);
        checkOutput("close_vip", int'(voting_in_progress), 0);
    endtask

    task automatic queryDut(input logic [1:0] sel, input logic win, input string tag);
        applyStimulus(1, 0, 0, 0, 0, 0, sel, win);
        predict(sel, win, tag);
        tick();
        compareScoreboard();
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();

        // Scenario 1: three ballots for candidate 2.
        $display("[TB] scenario 1: basic ballots");
        doReset("s1");
        for (int i = 0; i < 3; i++) castBallot(0, 1, 0, i == 0);
        closeSession();
        queryDut(2'b10, 0, "s1_c2");
        checkOutput("s1_voting_done", int'(voting_done), 1);
        queryDut(2'b01, 0, "s1_c1");
        queryDut(2'b00, 0, "s1_none");
        queryDut(2'b01, 1, "s1_winner");
        // Switch and vote lines are ignored once closed.
        applyStimulus(0, 1, 1, 0, 0, 0, 2'b11, 0);
        predict(2'b11, 0, "s1_ignore");
        tick();
        compareScoreboard();
        checkOutput("s1_done_held", int'(voting_done), 1);

        // Scenario 2: multi-press ballot counts nothing.
        $display("[TB] scenario 2: multi-press");
        doReset("s2");
        castBallot(1, 0, 1, 0);
        castBallot(1, 0, 0, 0);
        closeSession();
        queryDut(2'b01, 0, "s2_c1");
        queryDut(2'b11, 0, "s2_c3");

        // Scenario 3: button held for ten cycles counts once.
        $display("[TB] scenario 3: held button");
        doReset("s3");
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 0);
        tick();
        checkOutput("s3_vip_before", int'(voting_in_progress), 1);
        applyStimulus(1, 1, 1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) checkOutput("s3_vip_after", int'(voting_in_progress), 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        tal[0] = 1;
        closeSession();
        queryDut(2'b01, 0, "s3_c1");

        // Scenario 4: saturation at 127.
        $display("[TB] scenario 4: saturation");
        doReset("s4");
        for (int i = 0; i < 130; i++) castBallot(0, 0, 1, 0);
        castBallot(1, 0, 0, 0);
        closeSession();
        queryDut(2'b11, 0, "s4_c3");
        queryDut(2'b00, 0, "s4_total");
        queryDut(2'b00, 1, "s4_winner");

        // Scenario 5: tie at the maximum.
        $display("[TB] scenario 5: tie");
        doReset("s5");
        castBallot(1, 0, 0, 0);
        castBallot(0, 1, 0, 0);
        castBallot(1, 0, 0, 0);
        castBallot(0, 0, 1, 0);
        castBallot(0, 1, 0, 0);
        closeSession();
        queryDut(2'b00, 1, "s5_winner");
        queryDut(2'b10, 0, "s5_c2");

        // Scenario 6: asynchronous reset in the middle of a ballot.
        $display("[TB] scenario 6: async reset");
        doReset("s6");
        castBallot(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 0);
        tick();
        checkOutput("s6_vip_pre", int'(voting_in_progress), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("s6_async_vip", int'(voting_in_progress), 0);
        checkOutput("s6_async_done", int'(voting_done), 0);
        checkOutput("s6_async_results", int'(results), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tal[i] = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0);
        tick();
        closeSession();
        queryDut(2'b01, 0, "s6_c1");
        queryDut(2'b00, 1, "s6_winner_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
